// File: rtl/core_bridge_pkg.sv
// Shared TitanComms definitions used by the core bridge: instruction codes, run FSM states,
// address regions and CSR bit positions.
package core_bridge_pkg;

  typedef enum logic [7:0] {
    NOP   = 8'd0,
    READ  = 8'd1,
    WRITE = 8'd2
  } instructions;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    START   = 2'd1,
    RUN     = 2'd2,
    CAPTURE = 2'd3
  } core_bridge_state_t;

  typedef enum logic [1:0] {
    REGION_INPUT  = 2'd0,
    REGION_OUTPUT = 2'd1,
    REGION_CSR    = 2'd2
  } region_t;

  localparam int CSR_BUSY    = 0;
  localparam int CSR_DONE    = 1;
  localparam int CSR_TIMEOUT = 2;
  localparam int CSR_START   = 0;
  localparam int CSR_CLEAR   = 1;

  // Index width that stays at least one bit for single-entry ranges.
  function automatic int idx_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/core_address_decoder.sv
// Combinational decode of a comms address into ownership, region and word index within
// the region.
module core_address_decoder
  import core_bridge_pkg::*;
#(
  parameter int ADDR_WIDTH    = 24,
  parameter int START_ADDRESS = 0,
  parameter int TOTAL_INPUTS  = 2,
  parameter int TOTAL_OUTPUTS = 1,
  parameter int IDX_W         = 1
) (
  input  logic [ADDR_WIDTH-1:0] address,
  output logic                  enable,
  output logic [1:0]            region,
  output logic [IDX_W-1:0]      index
);

  localparam int END_ADDRESS = START_ADDRESS + TOTAL_INPUTS + TOTAL_OUTPUTS;
  localparam logic [ADDR_WIDTH-1:0] BASE = ADDR_WIDTH'(START_ADDRESS);
  localparam logic [ADDR_WIDTH-1:0] SPAN = ADDR_WIDTH'(END_ADDRESS - START_ADDRESS);
  localparam logic [ADDR_WIDTH-1:0] NIN  = ADDR_WIDTH'(TOTAL_INPUTS);

  logic [ADDR_WIDTH-1:0] offset;

  // Addresses below the base wrap to a large offset, so one compare covers both bounds.
  always_comb begin
    offset = address - BASE;
    enable = (offset <= SPAN);
    region = REGION_CSR;
    index  = '0;
    if (offset < NIN) begin
      region = REGION_INPUT;
      index  = IDX_W'(offset);
    end else if (offset < SPAN) begin
      region = REGION_OUTPUT;
      index  = IDX_W'(offset - NIN);
    end
  end

endmodule

// File: rtl/core_bridge.sv
// Maps a compute core's input registers, captured outputs and a control/status word into the
// comms address space, and sequences core runs with a start/done FSM guarded by a timeout.
module core_bridge
  import core_bridge_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDR_WIDTH    = 24,
  parameter int START_ADDRESS = 0,
  parameter int TOTAL_INPUTS  = 2,
  parameter int TOTAL_OUTPUTS = 1,
  parameter int AUTO_START    = 1,
  parameter int CORE_TIMEOUT  = 255
) (
  input  logic                              clock,
  input  logic                              reset_n,
  input  logic [7:0]                        instruction,
  input  logic [ADDR_WIDTH-1:0]             address,
  input  logic [DATA_WIDTH-1:0]             value,
  input  logic                              cmd_valid,
  output logic                              cmd_ready,
  output logic                              enable,
  output logic [DATA_WIDTH-1:0]             output_value,
  output logic                              output_valid,
  output logic [TOTAL_INPUTS*DATA_WIDTH-1:0]  core_inputs,
  output logic                              core_start,
  input  logic                              core_done,
  input  logic [TOTAL_OUTPUTS*DATA_WIDTH-1:0] core_outputs
);

  localparam int IW = idx_width((TOTAL_INPUTS > TOTAL_OUTPUTS) ? TOTAL_INPUTS : TOTAL_OUTPUTS);
  localparam int TW = idx_width(CORE_TIMEOUT + 1);

  core_bridge_state_t state, state_next;

  logic [1:0]                            region;
  logic [IW-1:0]                         idx;
  logic [DATA_WIDTH-1:0]                 in_regs [TOTAL_INPUTS];
  logic [TOTAL_OUTPUTS*DATA_WIDTH-1:0]   cap_regs;
  logic [TOTAL_INPUTS-1:0]               mask, wr_bit;
  logic [TW-1:0]                         timer;
  logic                                  done_flag, timeout_flag, busy;
  logic                                  is_read, is_write, wr_input, accept;
  logic                                  in_wr, csr_wr, rd, start_req, timed_out;
  logic [DATA_WIDTH-1:0]                 rdata;

  core_address_decoder #(
    .ADDR_WIDTH   (ADDR_WIDTH),
    .START_ADDRESS(START_ADDRESS),
    .TOTAL_INPUTS (TOTAL_INPUTS),
    .TOTAL_OUTPUTS(TOTAL_OUTPUTS),
    .IDX_W        (IW)
  ) u_decoder (
    .address(address),
    .enable (enable),
    .region (region),
    .index  (idx)
  );

  // Handshake: a command transfers on a cycle where cmd_valid and cmd_ready are both high;
  // cmd_ready depends only on the presented command and the run state, never on cmd_valid.
  always_comb begin
    is_read   = (instruction == READ);
    is_write  = (instruction == WRITE);
    wr_input  = is_write && (region == REGION_INPUT);
    cmd_ready = enable && (is_read || is_write) && !(wr_input && (state != IDLE));
    accept    = cmd_valid && cmd_ready;
    in_wr     = accept && wr_input;
    csr_wr    = accept && is_write && (region == REGION_CSR);
    rd        = accept && is_read;
    wr_bit    = in_wr ? (TOTAL_INPUTS'(1) << idx) : '0;
    // The write completing the mask counts immediately, so START follows its accept edge.
    start_req = (state == IDLE) &&
                (((AUTO_START != 0) && (&(mask | wr_bit))) || (csr_wr && value[CSR_START]));
    timed_out = (CORE_TIMEOUT != 0) && ((32'(timer) + 32'd1) == 32'(CORE_TIMEOUT));
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start_req) state_next = START;
      START:   state_next = RUN;
      RUN: begin
        if (core_done)      state_next = CAPTURE;
        else if (timed_out) state_next = IDLE;
      end
      CAPTURE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    core_start = (state == START);
    busy       = (state != IDLE);
  end

  always_comb begin
    rdata = '0;
    case (region)
      REGION_INPUT:  rdata = in_regs[idx];
      REGION_OUTPUT: rdata = cap_regs[int'(idx)*DATA_WIDTH +: DATA_WIDTH];
      default: begin
        rdata[CSR_BUSY]    = busy;
        rdata[CSR_DONE]    = done_flag;
        rdata[CSR_TIMEOUT] = timeout_flag;
      end
    endcase
  end

  always_comb begin
    for (int i = 0; i < TOTAL_INPUTS; i++)
      core_inputs[i*DATA_WIDTH +: DATA_WIDTH] = in_regs[i];
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < TOTAL_INPUTS; i++) in_regs[i] <= '0;
      cap_regs     <= '0;
      mask         <= '0;
      timer        <= '0;
      done_flag    <= 1'b0;
      timeout_flag <= 1'b0;
      output_value <= '0;
      output_valid <= 1'b0;
    end else begin
      if (in_wr) in_regs[idx] <= value;
      if (state == START) mask <= '0;
      else                mask <= mask | wr_bit;
      if (state == START)                      timer <= '0;
      else if ((state == RUN) && (timer != '1)) timer <= timer + 1'b1;
      if (state == CAPTURE) cap_regs <= core_outputs;
      // Clear first so a flag being set in the same cycle takes precedence.
      if (csr_wr && value[CSR_CLEAR]) begin
        done_flag    <= 1'b0;
        timeout_flag <= 1'b0;
      end
      if (state == CAPTURE) done_flag <= 1'b1;
      if ((state == RUN) && !core_done && timed_out) timeout_flag <= 1'b1;
      output_valid <= rd;
      if (rd) output_value <= rdata;
    end
  end

endmodule

// File: tb/tb_core_bridge.sv
// Randomized scoreboard bench for core_bridge with a stub core that finishes 3 cycles after start.
module tb_core_bridge;
  import core_bridge_pkg::*;

  localparam int DW = 32;
  localparam int AW = 24;
  localparam int TI = 2;
  localparam int TO = 1;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  logic [7:0]       instruction;
  logic [AW-1:0]    address;
  logic [DW-1:0]    value;
  logic             drv_valid, sel, hang;

  logic cmd_valid, cmd_ready, enable, output_valid, core_start, core_done;
  logic [DW-1:0]    output_value;
  logic [TI*DW-1:0] core_inputs;
  logic [TO*DW-1:0] core_outputs;
  logic cmd_valid_b, cmd_ready_b, enable_b, output_valid_b, core_start_b, core_done_b;
  logic [DW-1:0]    output_value_b;
  logic [TI*DW-1:0] core_inputs_b;
  logic [TO*DW-1:0] core_outputs_b;

  assign cmd_valid   = drv_valid & ~sel;
  assign cmd_valid_b = drv_valid & sel;

  // Stub cores: done three cycles after start, result is the sum of the input words.
  logic [2:0] sr, sr_b;
  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sr   <= '0;
      sr_b <= '0;
    end else begin
      sr   <= {sr[1:0], core_start};
      sr_b <= {sr_b[1:0], core_start_b};
    end
  end
  assign core_done      = sr[2] & ~hang;
  assign core_done_b    = sr_b[2];
  assign core_outputs   = core_inputs[DW-1:0] + core_inputs[2*DW-1:DW];
  assign core_outputs_b = core_inputs_b[DW-1:0] + core_inputs_b[2*DW-1:DW];

  core_bridge #(.AUTO_START(1), .CORE_TIMEOUT(8)) u_dut (
    .clock(clock), .reset_n(reset_n), .instruction(instruction), .address(address),
    .value(value), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .enable(enable),
    .output_value(output_value), .output_valid(output_valid), .core_inputs(core_inputs),
    .core_start(core_start), .core_done(core_done), .core_outputs(core_outputs)
  );

  core_bridge #(.AUTO_START(0), .CORE_TIMEOUT(255)) u_dut_m (
    .clock(clock), .reset_n(reset_n), .instruction(instruction), .address(address),
    .value(value), .cmd_valid(cmd_valid_b), .cmd_ready(cmd_ready_b), .enable(enable_b),
    .output_value(output_value_b), .output_valid(output_valid_b), .core_inputs(core_inputs_b),
    .core_start(core_start_b), .core_done(core_done_b), .core_outputs(core_outputs_b)
  );

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int failures = 0;
  int starts_a = 0, starts_b = 0, exp_starts_a = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] exp_q_b[$];

  // Reference model of the auto-start instance: register contents and sticky flags.
  logic [DW-1:0] m_in [TI];
  logic [DW-1:0] m_cap;
  logic          m_done, m_to;
  logic [TI-1:0] m_mask;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] exp_read(input int off);
    case (off)
      0:       return m_in[0];
      1:       return m_in[1];
      2:       return m_cap;
      default: return DW'({m_to, m_done, 1'b0});
    endcase
  endfunction

  task automatic model_reset();
    m_in[0] = '0; m_in[1] = '0; m_cap = '0; m_done = 1'b0; m_to = 1'b0; m_mask = '0;
  endtask

  task automatic do_run();
    m_mask = '0;
    exp_starts_a++;
    if (hang) m_to = 1'b1;
    else begin
      m_cap  = m_in[0] + m_in[1];
      m_done = 1'b1;
    end
  endtask

  // ---------------- monitors ----------------
  always @(negedge clock) begin
    if (core_start)   starts_a++;
    if (core_start_b) starts_b++;
    if (output_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_valid_a got=%h", output_value);
      end else begin
        logic [DW-1:0] e;
        e = exp_q.pop_front();
        if (output_value !== e) begin
          failures++;
          $display("FAIL read_a got=%h exp=%h", output_value, e);
        end
      end
    end
    if (output_valid_b) begin
      checks++;
      if (exp_q_b.size() == 0) begin
        failures++;
        $display("FAIL unexpected_valid_b got=%h", output_value_b);
      end else begin
        logic [DW-1:0] e;
        e = exp_q_b.pop_front();
        if (output_value_b !== e) begin
          failures++;
          $display("FAIL read_b got=%h exp=%h", output_value_b, e);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cmd(input bit s, input logic [7:0] ins, input logic [AW-1:0] a,
                     input logic [DW-1:0] v, output int waited);
    @(negedge clock);
    sel = s; instruction = ins; address = a; value = v; drv_valid = 1'b1; waited = 0;
    #1;
    while (!(s ? cmd_ready_b : cmd_ready) && waited < 64) begin
      @(negedge clock);
      #1;
      waited++;
    end
    if (waited >= 64) begin
      checks++;
      failures++;
      $display("FAIL cmd_ready_timeout addr=%h", a);
    end
    @(posedge clock);
    #1;
    drv_valid = 1'b0; instruction = NOP;
  endtask

  task automatic rd(input bit s, input int off, input logic [DW-1:0] e);
    int w;
    if (s) exp_q_b.push_back(e);
    else   exp_q.push_back(e);
    cmd(s, READ, AW'(off), '0, w);
    check("read_valid_latency", 64'(s ? output_valid_b : output_valid), 64'(1));
  endtask

  task automatic wr_input(input int i, input logic [DW-1:0] v, output bit started,
                          output int waited);
    cmd(1'b0, WRITE, AW'(i), v, waited);
    m_in[i] = v;
    m_mask[i] = 1'b1;
    started = &m_mask;
    check("start_after_input_write", 64'(core_start), 64'(started));
    if (started) do_run();
  endtask

  task automatic wr_csr(input logic [DW-1:0] v);
    int w;
    cmd(1'b0, WRITE, AW'(3), v, w);
    if (v[CSR_CLEAR]) begin
      m_done = 1'b0;
      m_to   = 1'b0;
    end
    check("start_after_csr_write", 64'(core_start), 64'(v[CSR_START]));
    if (v[CSR_START]) begin
      do_run();
      repeat (16) @(negedge clock);
    end
  endtask

  task automatic no_accept(input logic [7:0] ins, input logic [AW-1:0] a, input bit exp_en);
    @(negedge clock);
    sel = 1'b0; instruction = ins; address = a; value = $urandom; drv_valid = 1'b1;
    #1;
    check("enable_decode", 64'(enable), 64'(exp_en));
    check("ready_refused", 64'(cmd_ready), 64'(0));
    repeat (2) @(negedge clock);
    drv_valid = 1'b0; instruction = NOP;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int w;
    bit st;
    logic [DW-1:0] pre;
    instruction = NOP; address = '0; value = '0; drv_valid = 1'b0; sel = 1'b0; hang = 1'b0;
    model_reset();

    repeat (3) @(negedge clock);
    check("rst_output_valid", 64'(output_valid), 64'(0));
    check("rst_output_value", 64'(output_value), 64'(0));
    check("rst_core_start", 64'(core_start), 64'(0));
    check("rst_core_inputs", 64'(core_inputs), 64'(0));
    check("rst_nop_ready", 64'(cmd_ready), 64'(0));
    reset_n = 1'b1;
    rd(1'b0, 3, exp_read(3));

    // Basic run: second input write starts the core; CSR shows busy while it runs.
    wr_input(0, 32'h7, st, w);
    pre = exp_read(3);
    wr_input(1, 32'h3, st, w);
    rd(1'b0, 3, pre | 32'h1);
    repeat (16) @(negedge clock);
    rd(1'b0, 2, 32'hA);
    rd(1'b0, 3, 32'h2);

    // An input write during a run is held off until the FSM returns to IDLE.
    wr_input(0, 32'h5, st, w);
    wr_input(1, 32'h6, st, w);
    wr_input(0, 32'h9, st, w);
    check("held_write_wait_cycles", 64'(w), 64'(5));
    repeat (16) @(negedge clock);
    rd(1'b0, 2, exp_read(2));
    rd(1'b0, 0, 32'h9);

    // Timeout: the core never finishes; busy through the 8th RUN cycle, IDLE after it.
    wr_csr(32'h2);
    hang = 1'b1;
    pre = exp_read(3);
    wr_input(1, $urandom, st, w);
    repeat (8) @(negedge clock);
    rd(1'b0, 3, pre | 32'h1);
    rd(1'b0, 3, 32'h4);
    rd(1'b0, 2, exp_read(2));
    hang = 1'b0;

    // CSR clear landing in the CAPTURE cycle: done still ends up set, timeout is cleared.
    cmd(1'b0, WRITE, AW'(3), 32'h1, w);
    check("csr_manual_start", 64'(core_start), 64'(1));
    do_run();
    repeat (4) @(negedge clock);
    cmd(1'b0, WRITE, AW'(3), 32'h2, w);
    m_to = 1'b0;
    m_done = 1'b1;
    repeat (16) @(negedge clock);
    rd(1'b0, 3, 32'h2);
    rd(1'b0, 2, exp_read(2));

    // Asynchronous reset in the middle of a run.
    hang = 1'b1;
    wr_csr(32'h1);
    hang = 1'b0;
    rd(1'b0, 0, exp_read(0));
    hang = 1'b1;
    cmd(1'b0, WRITE, AW'(3), 32'h1, w);
    check("start_before_reset", 64'(core_start), 64'(1));
    exp_starts_a++;
    repeat (3) @(negedge clock);
    #2 reset_n = 1'b0;
    #1;
    check("async_rst_core_start", 64'(core_start), 64'(0));
    check("async_rst_output_valid", 64'(output_valid), 64'(0));
    check("async_rst_output_value", 64'(output_value), 64'(0));
    check("async_rst_core_inputs", 64'(core_inputs), 64'(0));
    model_reset();
    hang = 1'b0;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    rd(1'b0, 3, 32'h0);
    rd(1'b0, 2, 32'h0);

    // Randomized traffic against the reference model.
    for (int n = 0; n < 120; n++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r <= 2) begin
        wr_input($urandom_range(0, TI - 1), $urandom, st, w);
        if (st) repeat (16) @(negedge clock);
      end else if (r == 3) begin
        cmd(1'b0, WRITE, AW'(2), $urandom, w);
        check("output_write_no_start", 64'(core_start), 64'(0));
      end else if (r == 4) begin
        wr_csr($urandom);
      end else if (r <= 7) begin
        int off;
        off = $urandom_range(0, 3);
        rd(1'b0, off, exp_read(off));
      end else if (r == 8) begin
        if ($urandom_range(0, 1) == 0)
          no_accept(($urandom_range(0, 1) == 0) ? READ : WRITE, AW'($urandom_range(4, 24'hFFFFFF)), 1'b0);
        else
          no_accept(NOP, AW'($urandom_range(0, 3)), 1'b1);
      end else begin
        hang = ($urandom_range(0, 3) == 0);
      end
    end
    for (int off = 0; off < 4; off++) rd(1'b0, off, exp_read(off));

    // Manual-start instance: a full input mask alone never starts the core.
    cmd(1'b1, WRITE, AW'(0), 32'h11, w);
    cmd(1'b1, WRITE, AW'(1), 32'h22, w);
    repeat (10) @(negedge clock);
    check("manual_no_autostart", 64'(starts_b), 64'(0));
    rd(1'b1, 3, 32'h0);
    cmd(1'b1, WRITE, AW'(3), 32'h1, w);
    check("manual_csr_start", 64'(core_start_b), 64'(1));
    repeat (16) @(negedge clock);
    rd(1'b1, 2, 32'h33);
    rd(1'b1, 3, 32'h2);
    cmd(1'b1, WRITE, AW'(3), 32'h2, w);
    rd(1'b1, 3, 32'h0);
    repeat (4) @(negedge clock);
    check("manual_start_count", 64'(starts_b), 64'(1));

    // ---------------- final report ----------------
    check("auto_start_count", 64'(starts_a), 64'(exp_starts_a));
    check("pending_reads_a", 64'(exp_q.size()), 64'(0));
    check("pending_reads_b", 64'(exp_q_b.size()), 64'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
